// File: rtl/l2_timeout_wdog.sv
// L2 command-timeout watchdog: programmable timeout, clock prescaler, sticky error with clear.
// Optional half-way warning output is enabled by defining L2_TIMER_WARN_EN.
module l2_timeout_wdog #(
    parameter int CNT_W   = 21,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pin_timer_disable_i,
    input  logic               l3_en_i,
    input  logic               l3_cmd_done_i,
    input  logic               timer_stop_i,
    input  logic               err_clr_i,
    input  logic [CNT_W-1:0]   cfg_timeout_i,
    input  logic [PRESC_W-1:0] cfg_presc_i,
    output logic               timer_busy_o,
    output logic [CNT_W-1:0]   timer_cnt_o,
`ifdef L2_TIMER_WARN_EN
    output logic               timer_warn_o,
`endif
    output logic               err_timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   tmo_l_q, tmo_l_d;
    logic [PRESC_W-1:0] presc_l_q, presc_l_d;
    logic               expired_q, expired_d;
    logic               warn_q, warn_d;
    logic               tick;

    assign tick = (presc_cnt_q == presc_l_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            presc_cnt_q <= '0;
            tmo_l_q     <= '0;
            presc_l_q   <= '0;
            expired_q   <= 1'b0;
            warn_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            presc_cnt_q <= presc_cnt_d;
            tmo_l_q     <= tmo_l_d;
            presc_l_q   <= presc_l_d;
            expired_q   <= expired_d;
            warn_q      <= warn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        presc_cnt_d = '0;
        tmo_l_d     = tmo_l_q;
        presc_l_d   = presc_l_q;
        expired_d   = expired_q;
        warn_d      = 1'b0;

        if (l3_en_i) begin
            // Restart from any state; configuration is frozen for the whole run.
            state_d   = RUN;
            tmo_l_d   = cfg_timeout_i;
            presc_l_d = cfg_presc_i;
            expired_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (l3_cmd_done_i || timer_stop_i) begin
                        state_d = IDLE;
                    end else if (!tick) begin
                        cnt_d       = cnt_q;
                        presc_cnt_d = presc_cnt_q + PRESC_ONE;
                        warn_d      = warn_q;
                    end else if ((tmo_l_q != '0) && (cnt_q == tmo_l_q - CNT_ONE)) begin
                        state_d   = EXPIRED;
                        expired_d = 1'b1;
                    end else begin
                        // Saturate only matters for the never-expire (tmo_l == 0) case.
                        cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                        warn_d = warn_q ||
                                 ((tmo_l_q > CNT_ONE) && (cnt_d == (tmo_l_q >> 1)));
                    end
                end
                EXPIRED: begin
                    if (err_clr_i) begin
                        state_d   = IDLE;
                        expired_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign err_timeout_o = expired_q & ~pin_timer_disable_i;
    assign timer_busy_o  = (state_q == RUN);
    assign timer_cnt_o   = cnt_q;

`ifdef L2_TIMER_WARN_EN
    assign timer_warn_o = warn_q;
`else
    logic unused_warn;
    assign unused_warn = warn_q;
`endif

endmodule

// File: tb/tb_l2_timeout_wdog.sv
// Self-checking bench for l2_timeout_wdog: directed T1-T6 scenarios, async reset, random traffic.
// The reference model tracks elapsed cycles since start and derives ticks arithmetically.
module tb_l2_timeout_wdog;

    localparam int CNT_W   = 4;
    localparam int PRESC_W = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pin = 1'b0;
    logic               l3_en = 1'b0;
    logic               done = 1'b0;
    logic               stop = 1'b0;
    logic               clr = 1'b0;
    logic [CNT_W-1:0]   cfg_tmo = '0;
    logic [PRESC_W-1:0] cfg_presc = '0;
    logic               busy;
    logic [CNT_W-1:0]   cnt;
    logic               err;
`ifdef L2_TIMER_WARN_EN
    logic               warn;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_run, m_exp;
    int m_elapsed, m_tmo, m_presc;

    always #5 clk = ~clk;

    l2_timeout_wdog #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pin_timer_disable_i (pin),
        .l3_en_i             (l3_en),
        .l3_cmd_done_i       (done),
        .timer_stop_i        (stop),
        .err_clr_i           (clr),
        .cfg_timeout_i       (cfg_tmo),
        .cfg_presc_i         (cfg_presc),
        .timer_busy_o        (busy),
        .timer_cnt_o         (cnt),
`ifdef L2_TIMER_WARN_EN
        .timer_warn_o        (warn),
`endif
        .err_timeout_o       (err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt();
        int c;
        if (!m_run) return 0;
        c = m_elapsed / (m_presc + 1);
        return (c > SAT) ? SAT : c;
    endfunction

    function automatic int exp_warn();
        return (m_run && m_tmo >= 2 && exp_cnt() >= (m_tmo >> 1)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_exp = 0; m_elapsed = 0; m_tmo = 0; m_presc = 0;
    endtask

    task automatic model_edge();
        if (l3_en) begin
            m_run = 1; m_exp = 0; m_elapsed = 0;
            m_tmo = int'(cfg_tmo); m_presc = int'(cfg_presc);
        end else if (m_run) begin
            if (done || stop) begin
                m_run = 0;
            end else begin
                m_elapsed++;
                if (m_tmo != 0 && m_elapsed == m_tmo * (m_presc + 1)) begin
                    m_run = 0; m_exp = 1;
                end
            end
        end else if (m_exp && clr) begin
            m_exp = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"}, int'(busy), int'(m_run));
        chk({tag, ".cnt"}, int'(cnt), exp_cnt());
        chk({tag, ".err"}, int'(err), int'(m_exp && !pin));
`ifdef L2_TIMER_WARN_EN
        chk({tag, ".warn"}, int'(warn), exp_warn());
`endif
    endtask

    // one clock edge: model consumes the same inputs the DUT samples, then pulses drop
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        l3_en = 0; done = 0; stop = 0; clr = 0;
    endtask

    task automatic start(input int tmo, input int presc, input string tag);
        cfg_tmo = CNT_W'(tmo); cfg_presc = PRESC_W'(presc); l3_en = 1;
        step(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1;
        @(negedge clk);

        // T1: timeout 4, no prescale
        start(4, 0, "t1_start");
        for (int i = 1; i <= 6; i++) step("t1_run");
        chk("t1_err_stuck", int'(err), 1);

        // T2: timeout 3, prescale 3, then clear
        start(3, 2, "t2_start");
        for (int i = 1; i <= 9; i++) step("t2_run");
        chk("t2_err_at_9", int'(err), 1);
        clr = 1; step("t2_clr");
        chk("t2_err_cleared", int'(err), 0);
        done = 1; stop = 1; clr = 1; step("t2_idle_noeffect");

        // T3: done coincides with expiry
        start(5, 0, "t3_start");
        for (int i = 1; i <= 4; i++) step("t3_run");
        done = 1; step("t3_done_wins");
        step("t3_after");
        chk("t3_no_err", int'(err), 0);

        // T4: masked expiry, unmask combinationally
        pin = 1;
        start(2, 1, "t4_start");
        for (int i = 1; i <= 5; i++) step("t4_run");
        chk("t4_masked", int'(err), 0);
        pin = 0; #1;
        chk("t4_unmask", int'(err), 1);
        stop = 1; done = 1; step("t4_stop_ignored");

        // T6: restart from EXPIRED (warn at 4th edge when enabled)
        start(8, 0, "t6_restart");
        chk("t6_err_clear", int'(err), 0);
        for (int i = 1; i <= 9; i++) step("t6_run");

        // T5: never expire, saturation
        start(0, 0, "t5_start");
        for (int i = 0; i < (1 << CNT_W) + 10; i++) step("t5_run");
        chk("t5_sat", int'(cnt), SAT);
        stop = 1; step("t5_stop");

        // async reset mid-run and with pending error
        start(6, 1, "rst_start");
        for (int i = 0; i < 5; i++) step("rst_run");
        @(negedge clk);
        rst_n = 0; #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk); rst_n = 1;
        start(1, 0, "rst_exp_start");
        step("rst_exp");
        @(negedge clk);
        rst_n = 0; #1;
        model_reset();
        check_all("rst_pending_err");
        @(negedge clk); rst_n = 1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            pin   = ($urandom_range(0, 9) == 0) ? ~pin : pin;
            l3_en = ($urandom_range(0, 19) == 0);
            done  = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            cfg_tmo   = CNT_W'($urandom_range(0, SAT));
            cfg_presc = PRESC_W'($urandom_range(0, 3));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "test done: total=%0d bad=%0d", total, bad);
    end

endmodule
